// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
// Framing enums, latched frame bundle and config clamps.
package uart_pkg;

    localparam int MIN_DATA_WD = 5;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        ODD   = 3'd1,
        EVEN  = 3'd2,
        MARK  = 3'd3,
        SPACE = 3'd4
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK,
        BRK_MARK
    } tx_state_e;

    typedef struct packed {
        logic [3:0] n;
        logic       par_en;
        logic       par_bit;
        logic       stop2;
    } frame_cfg_t;

    function automatic logic [3:0] clamp_bits(input logic [3:0] bits,
                                              input int max_wd);
        if (int'(bits) < MIN_DATA_WD) return 4'(MIN_DATA_WD);
        if (int'(bits) > max_wd) return 4'(max_wd);
        return bits;
    endfunction

    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'd2) ? 32'd2 : div;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: one-clock bit_tick every div clocks,
// phase realigned by restart.
module uart_baud_gen #(
    parameter int DIV_WD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic [DIV_WD-1:0] div,
    output logic              bit_tick
);

    logic [DIV_WD-1:0] cnt;
    logic              last;

    // >= keeps the counter bounded if div shrinks while it free-runs
    assign last     = cnt >= (div - DIV_WD'(1));
    assign bit_tick = last && !restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_WD'(1);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime framing, parity, stop bits and break.
// Config is sampled on each transfer and held for the whole frame.
module uart_tx_cfg #(
    parameter int DIV_WD      = 16,
    parameter int MAX_DATA_WD = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIV_WD-1:0]      cfg_div,
    input  logic [3:0]             cfg_data_bits,
    input  logic [2:0]             cfg_parity,
    input  logic                   cfg_stop2,
    input  logic                   s_valid,
    input  logic [MAX_DATA_WD-1:0] s_data,
    output logic                   s_ready,
    input  logic                   tx_break,
    output logic                   uart_tx,
    output logic                   busy,
    output logic                   tx_done
);

    import uart_pkg::*;

    tx_state_e              state;
    frame_cfg_t             fcfg;
    logic [DIV_WD-1:0]      div_q;
    logic [DIV_WD-1:0]      div_eff;
    logic [MAX_DATA_WD-1:0] shreg;
    logic [MAX_DATA_WD-1:0] data_m;
    logic [3:0]             n_eff;
    logic [3:0]             bit_cnt;
    logic                   par_en;
    logic                   par_bit;
    logic                   bit_tick;
    logic                   xfer;
    logic                   restart;
    logic                   last_stop;

    assign s_ready   = (state == IDLE) && !tx_break;
    assign busy      = (state != IDLE);
    assign xfer      = s_valid && s_ready;
    assign restart   = xfer || ((state == BRK) && !tx_break);
    assign n_eff     = clamp_bits(cfg_data_bits, MAX_DATA_WD);
    assign div_eff   = DIV_WD'(clamp_div(32'(cfg_div)));
    assign data_m    = s_data & ~({MAX_DATA_WD{1'b1}} << n_eff);
    assign last_stop = (bit_cnt == (fcfg.stop2 ? 4'd2 : 4'd1));
    assign tx_done   = (state == STOP) && bit_tick && last_stop;

    // data_m is already masked, so the reduction covers data[N-1:0]
    always_comb begin
        par_en  = 1'b1;
        par_bit = 1'b0;
        unique case (cfg_parity)
            ODD:     par_bit = ~^data_m;
            EVEN:    par_bit = ^data_m;
            MARK:    par_bit = 1'b1;
            SPACE:   par_bit = 1'b0;
            default: par_en  = 1'b0;
        endcase
    end

    uart_baud_gen #(
        .DIV_WD (DIV_WD)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (restart),
        .div      (div_q),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            uart_tx <= 1'b1;
            div_q   <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            fcfg    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (tx_break) begin
                        state   <= BRK;
                        uart_tx <= 1'b0;
                        div_q   <= div_eff;
                    end else if (s_valid) begin
                        state   <= START;
                        uart_tx <= 1'b0;
                        div_q   <= div_eff;
                        shreg   <= data_m;
                        bit_cnt <= '0;
                        fcfg    <= '{n: n_eff, par_en: par_en,
                                     par_bit: par_bit, stop2: cfg_stop2};
                    end
                end
                START: if (bit_tick) begin
                    state   <= DATA;
                    uart_tx <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_cnt <= 4'd1;
                end
                DATA: if (bit_tick) begin
                    if (bit_cnt == fcfg.n) begin
                        if (fcfg.par_en) begin
                            state   <= PARITY;
                            uart_tx <= fcfg.par_bit;
                        end else begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                            bit_cnt <= 4'd1;
                        end
                    end else begin
                        uart_tx <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                PARITY: if (bit_tick) begin
                    state   <= STOP;
                    uart_tx <= 1'b1;
                    bit_cnt <= 4'd1;
                end
                STOP: if (bit_tick) begin
                    if (last_stop) state <= IDLE;
                    else bit_cnt <= bit_cnt + 4'd1;
                end
                BRK: if (!tx_break) begin
                    state   <= BRK_MARK;
                    uart_tx <= 1'b1;
                    bit_cnt <= '0;
                end
                BRK_MARK: if (bit_tick) begin
                    if (bit_cnt == 4'd1) state <= IDLE;
                    else bit_cnt <= bit_cnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed scoreboard bench for uart_tx_cfg: per-clock expected
// line/ready/busy/done samples are queued and checked at negedges.
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cfg_div;
    logic [3:0]  cfg_data_bits;
    logic [2:0]  cfg_parity;
    logic        cfg_stop2;
    logic        s_valid;
    logic [8:0]  s_data;
    logic        s_ready;
    logic        tx_break;
    logic        uart_tx;
    logic        busy;
    logic        tx_done;

    typedef struct packed {
        logic line;
        logic ready;
        logic busy;
        logic done;
    } samp_t;

    samp_t q[$];
    int    cmps = 0;
    int    errs = 0;

    uart_tx_cfg #(
        .DIV_WD      (16),
        .MAX_DATA_WD (9)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_div       (cfg_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .tx_break      (tx_break),
        .uart_tx       (uart_tx),
        .busy          (busy),
        .tx_done       (tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        cmps++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input string tag);
        samp_t e;
        @(negedge clk);
        cmps++;
        assert (q.size() != 0) else begin
            errs++;
            $error("FAIL %s/queue: observed empty expected sample", tag);
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({tag, "/line"}, uart_tx, e.line);
            chk({tag, "/ready"}, s_ready, e.ready);
            chk({tag, "/busy"}, busy, e.busy);
            chk({tag, "/done"}, tx_done, e.done);
        end
    endtask

    task automatic set_cfg(input int dv, input int bits,
                           input int par, input bit s2);
        cfg_div       = 16'(dv);
        cfg_data_bits = 4'(bits);
        cfg_parity    = 3'(par);
        cfg_stop2     = s2;
    endtask

    // Reference framing model; returns frame length in clocks.
    function automatic int push_frame(input logic [8:0] d, input int bits,
                                      input int par, input bit s2,
                                      input int dv);
        logic b[$];
        logic p;
        int   n, ln;
        n  = (bits < 5) ? 5 : ((bits > 9) ? 9 : bits);
        dv = (dv < 2) ? 2 : dv;
        p  = 1'b0;
        b.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            b.push_back(d[i]);
            p ^= d[i];
        end
        case (par)
            1: b.push_back(~p);
            2: b.push_back(p);
            3: b.push_back(1'b1);
            4: b.push_back(1'b0);
            default: ;
        endcase
        b.push_back(1'b1);
        if (s2) b.push_back(1'b1);
        ln = b.size() * dv;
        for (int k = 0; k < ln; k++)
            q.push_back(samp_t'{b[k / dv], 1'b0, 1'b1, logic'(k == ln - 1)});
        return ln;
    endfunction

    task automatic push_const(input int n, input logic line,
                              input logic ready, input logic bsy);
        for (int k = 0; k < n; k++)
            q.push_back(samp_t'{line, ready, bsy, 1'b0});
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            step(tag);
            if (k == 0) s_valid = 1'b0;
        end
    endtask

    initial begin
        logic [8:0] words [3];
        int         ln;

        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        tx_break = 1'b0;
        set_cfg(4, 8, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("reset/line", uart_tx, 1'b1);
        chk("reset/busy", busy, 1'b0);
        chk("reset/done", tx_done, 1'b0);
        chk("reset/ready", s_ready, 1'b1);

        set_cfg(4, 8, 0, 0);
        s_data = 9'h0A5;
        ln = push_frame(9'h0A5, 8, 0, 0, 4);
        chk("8n1/len40", logic'(ln == 40), 1'b1);
        push_const(2, 1'b1, 1'b1, 1'b0);
        s_valid = 1'b1;
        run("8n1", ln + 2);

        set_cfg(3, 7, 2, 1);
        s_data = 9'h003;
        ln = push_frame(9'h003, 7, 2, 1, 3);
        chk("7e2/len33", logic'(ln == 33), 1'b1);
        push_const(1, 1'b1, 1'b1, 1'b0);
        s_valid = 1'b1;
        run("7e2", ln + 1);

        set_cfg(3, 7, 1, 1);
        ln = push_frame(9'h003, 7, 1, 1, 3);
        push_const(1, 1'b1, 1'b1, 1'b0);
        s_valid = 1'b1;
        run("7o2", ln + 1);

        set_cfg(2, 12, 3, 0);
        s_data = 9'h1FF;
        ln = push_frame(9'h1FF, 12, 3, 0, 2);
        push_const(1, 1'b1, 1'b1, 1'b0);
        s_valid = 1'b1;
        run("9m1", ln + 1);

        set_cfg(2, 9, 4, 0);
        ln = push_frame(9'h1FF, 9, 4, 0, 2);
        push_const(1, 1'b1, 1'b1, 1'b0);
        s_valid = 1'b1;
        run("9s1", ln + 1);

        set_cfg(1, 3, 2, 0);
        ln = push_frame(9'h1FF, 3, 2, 0, 1);
        push_const(1, 1'b1, 1'b1, 1'b0);
        s_valid = 1'b1;
        run("5e1_div1", ln + 1);

        words[0] = 9'h011;
        words[1] = 9'h0FE;
        words[2] = 9'h15A;
        set_cfg(4, 8, 0, 0);
        for (int f = 0; f < 3; f++) begin
            ln = push_frame(words[f], 8, 0, 0, 4);
            push_const(1, 1'b1, 1'b1, 1'b0);
        end
        s_data  = words[0];
        s_valid = 1'b1;
        for (int c = 0; c < 3 * 41; c++) begin
            step("b2b");
            if (c % 41 == 0) begin
                if (c / 41 < 2) s_data = words[c / 41 + 1];
                else s_valid = 1'b0;
            end
        end

        s_data = 9'h03C;
        ln = push_frame(9'h03C, 8, 0, 0, 4);
        push_const(1, 1'b1, 1'b0, 1'b0);
        push_const(19, 1'b0, 1'b0, 1'b1);
        push_const(8, 1'b1, 1'b0, 1'b1);
        push_const(2, 1'b1, 1'b1, 1'b0);
        s_valid = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            step("break");
            if (c == 1) s_valid = 1'b0;
            if (c == 10) tx_break = 1'b1;
            if (c == 60) tx_break = 1'b0;
        end

        set_cfg(4, 8, 2, 0);
        s_data = 9'h0C3;
        ln = push_frame(9'h0C3, 8, 2, 0, 4);
        push_const(1, 1'b1, 1'b1, 1'b0);
        s_valid = 1'b1;
        for (int c = 1; c <= ln + 1; c++) begin
            step("cfgchg");
            if (c == 1) s_valid = 1'b0;
            if (c == 5) set_cfg(7, 5, 1, 1);
        end

        set_cfg(4, 8, 0, 0);
        s_data = 9'h05A;
        ln = push_frame(9'h05A, 8, 0, 0, 4);
        s_valid = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            step("prerst");
            if (c == 1) s_valid = 1'b0;
        end
        q.delete();
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst/line", uart_tx, 1'b1);
        chk("async_rst/busy", busy, 1'b0);
        chk("async_rst/done", tx_done, 1'b0);
        #1 rst_n = 1'b1;
        push_const(20, 1'b1, 1'b1, 1'b0);
        run("postrst", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
